// File: rtl/multicycle_proc_controller_if.sv
// Control bundle between the multicycle controller, the datapath and the memory ports.
// Latency: none, this file only carries wires.
// Backpressure: imemReq/imemAck and dmemReq/dmemAck are level-held request/ack pairs.
interface multicycle_proc_controller_if #(
  parameter int OP_BIT_WIDTH = 4,
  parameter int CNT_BITS     = 32
);
  logic                    lock;
  logic [OP_BIT_WIDTH-1:0] op1;
  logic [OP_BIT_WIDTH-1:0] op2;
  logic                    outCond;
  logic                    imemAck;
  logic                    dmemAck;

  logic                    imemReq;
  logic                    dmemReq;
  logic                    wrtEnMem;
  logic                    wrtEnReg;
  logic                    pcWrtEn;
  logic                    useImmPc;
  logic                    isJal;
  logic                    isMvhi;
  logic                    useZeroExe;
  logic                    useImmExe;
  logic                    isBranchOrCond;
  logic [OP_BIT_WIDTH-1:0] opAlu;
  logic [OP_BIT_WIDTH-1:0] opCond;
  logic [1:0]              wbSel;
  logic [CNT_BITS-1:0]     retired;
  logic                    fault;
  logic                    busy;

  // Datapath / memory side: drives opcodes, run enable and acks.
  modport master (
    output lock, op1, op2, outCond, imemAck, dmemAck,
    input  imemReq, dmemReq, wrtEnMem, wrtEnReg, pcWrtEn, useImmPc,
           isJal, isMvhi, useZeroExe, useImmExe, isBranchOrCond,
           opAlu, opCond, wbSel, retired, fault, busy
  );

  // Controller side.
  modport slave (
    input  lock, op1, op2, outCond, imemAck, dmemAck,
    output imemReq, dmemReq, wrtEnMem, wrtEnReg, pcWrtEn, useImmPc,
           isJal, isMvhi, useZeroExe, useImmExe, isBranchOrCond,
           opAlu, opCond, wbSel, retired, fault, busy
  );
endinterface

// File: rtl/multicycle_proc_controller.sv
// Multi-cycle processor controller: FETCH/DECODE/EXEC/MEM/WB sequencing plus opcode decode.
// Latency: 4 cycles per ALU/JAL/branch, 5 per LW/SW, +1 per memory wait cycle.
// Backpressure: holds imemReq/dmemReq until ack; MEM_TIMEOUT unacked waits -> sticky fault, HALT.
module multicycle_proc_controller #(
  parameter int                      OP_BIT_WIDTH = 4,
  parameter int                      DBITS        = 32,
  parameter logic [OP_BIT_WIDTH-1:0] OP2_SUB      = 4'b0110,
  parameter int                      MEM_TIMEOUT  = 255,
  parameter int                      TO_BITS      = 8,
  parameter int                      CNT_BITS     = 32
) (
  input logic                      clk,
  input logic                      resetN,
  multicycle_proc_controller_if.slave bus
);

  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;

  localparam logic [TO_BITS-1:0] TO_LIMIT = TO_BITS'(MEM_TIMEOUT);

  // Reject parameter sets the timeout counter cannot represent.
  if (MEM_TIMEOUT < 1 || MEM_TIMEOUT > (2**TO_BITS) - 1 || DBITS < 1) begin : g_param_check
    $error("multicycle_proc_controller: MEM_TIMEOUT/TO_BITS/DBITS out of range");
  end

  state_t              state;
  state_t              state_nxt;
  logic [TO_BITS-1:0]  to_cnt;
  logic [CNT_BITS-1:0] retired;
  logic                fault;
  logic                waiting;
  logic                timeout;

  logic is_jal, is_sw, is_br, is_lw, reg_wr, br_cond, is_mvhi;
  logic imem_req, dmem_req, wrt_mem, wrt_reg, pc_wrt, imm_pc;

  // Opcode decode is purely combinational; the op fields are stable from DECODE onward.
  assign is_jal  = bus.op1[1] & bus.op1[0];
  assign is_sw   = bus.op1[2] & bus.op1[0];
  assign is_br   = bus.op1[2] & ~bus.op1[0];
  assign is_lw   = bus.op1[0] & ~bus.op1[1] & ~bus.op1[2];
  assign reg_wr  = ~bus.op1[2];
  assign br_cond = bus.op1[1] & ~bus.op1[0];
  assign is_mvhi = bus.op1[3] & ~bus.op1[1] & bus.op2[1] & bus.op2[0];

  assign bus.isJal          = is_jal;
  assign bus.isMvhi         = is_mvhi;
  assign bus.isBranchOrCond = br_cond;
  assign bus.useZeroExe     = (is_br & bus.op2[2]) | is_mvhi;
  assign bus.useImmExe      = bus.op1[3] | is_sw;
  assign bus.opAlu          = br_cond ? OP2_SUB : bus.op2;
  assign bus.opCond         = bus.op2;
  assign bus.wbSel          = is_jal ? 2'd2 : (is_lw ? 2'd1 : 2'd0);

  // Next-state and per-state strobes; each strobe belongs to exactly one state.
  always_comb begin
    state_nxt = state;
    waiting   = 1'b0;
    timeout   = 1'b0;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    wrt_mem   = 1'b0;
    wrt_reg   = 1'b0;
    pc_wrt    = 1'b0;
    imm_pc    = 1'b0;
    case (state)
      IDLE: begin
        if (bus.lock) state_nxt = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (bus.imemAck) begin
          state_nxt = DECODE;
        end else if (to_cnt == TO_LIMIT) begin
          timeout   = 1'b1;
          state_nxt = HALT;
        end else begin
          waiting = 1'b1;
        end
      end
      DECODE: state_nxt = EXEC;
      EXEC: begin
        state_nxt = (is_lw | is_sw) ? MEM : WB;
      end
      MEM: begin
        dmem_req = 1'b1;
        wrt_mem  = is_sw;
        if (bus.dmemAck) begin
          state_nxt = WB;
        end else if (to_cnt == TO_LIMIT) begin
          timeout   = 1'b1;
          state_nxt = HALT;
        end else begin
          waiting = 1'b1;
        end
      end
      WB: begin
        wrt_reg   = reg_wr;
        pc_wrt    = 1'b1;
        imm_pc    = is_br & bus.outCond;
        state_nxt = bus.lock ? FETCH : IDLE;
      end
      HALT: state_nxt = HALT;
      default: state_nxt = IDLE;
    endcase
  end

  // State, wait counter (zero outside an unacked wait), sticky fault and retire count.
  always_ff @(posedge clk) begin
    if (!resetN) begin
      state   <= IDLE;
      to_cnt  <= '0;
      retired <= '0;
      fault   <= 1'b0;
    end else begin
      state  <= state_nxt;
      to_cnt <= waiting ? to_cnt + TO_BITS'(1) : '0;
      if (timeout) fault <= 1'b1;
      if (state == WB) retired <= retired + CNT_BITS'(1);
    end
  end

  assign bus.imemReq  = imem_req;
  assign bus.dmemReq  = dmem_req;
  assign bus.wrtEnMem = wrt_mem;
  assign bus.wrtEnReg = wrt_reg;
  assign bus.pcWrtEn  = pc_wrt;
  assign bus.useImmPc = imm_pc;
  assign bus.retired  = retired;
  assign bus.fault    = fault;
  assign bus.busy     = (state != IDLE) && (state != HALT);

endmodule

// File: tb/tb_multicycle_proc_controller.sv
// Bench for multicycle_proc_controller: directed instruction stream with a per-cycle timeline model.
// Latency: expected outputs are derived per instruction from fetch/decode/exec/mem/wb phase lengths.
// Backpressure: imemAck/dmemAck are driven on a fixed delay schedule chosen per instruction.
module tb_multicycle_proc_controller;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  multicycle_proc_controller_if #(.OP_BIT_WIDTH(4), .CNT_BITS(4)) bus ();

  multicycle_proc_controller #(
    .OP_BIT_WIDTH(4), .DBITS(32), .OP2_SUB(4'b0110),
    .MEM_TIMEOUT(4), .TO_BITS(8), .CNT_BITS(4)
  ) dut (
    .clk(clk), .resetN(resetN), .bus(bus)
  );

  // Hand-decoded instruction table: opcodes, expected selects, and instruction class.
  typedef struct {
    logic [3:0] op1, op2;
    bit jal, mvhi, zero, imm, brc;
    logic [3:0] alu;
    logic [1:0] wb;
    int mem;            // 0 none, 1 load, 2 store
    bit regw, br;
  } ins_t;

  typedef struct {
    bit ireq, dreq, wmem, wreg, pcw, immpc, bsy, flt;
    logic [3:0] ret;
    int dec;
    bit pin;
    logic [3:0] pin_ret;
    bit pin_flt;
  } exp_t;

  localparam int I_ADD = 0, I_SW = 1, I_BR = 2, I_CMP = 3, I_MVHI = 4, I_LW = 5, I_JAL = 6;

  ins_t tbl [7];
  exp_t expq [$];
  int total = 0;
  int bad = 0;
  int m_retired = 0;
  bit m_fault = 1'b0;
  bit p_en = 1'b0;
  logic [3:0] p_ret = '0;
  bit p_flt = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // Compare process: one expected record per cycle, checked mid-cycle.
  always @(negedge clk) begin
    exp_t e;
    if (expq.size() > 0) begin
      e = expq.pop_front();
      chk("imemReq", bus.imemReq, e.ireq);
      chk("dmemReq", bus.dmemReq, e.dreq);
      chk("wrtEnMem", bus.wrtEnMem, e.wmem);
      chk("wrtEnReg", bus.wrtEnReg, e.wreg);
      chk("pcWrtEn", bus.pcWrtEn, e.pcw);
      chk("useImmPc", bus.useImmPc, e.immpc);
      chk("busy", bus.busy, e.bsy);
      chk("fault", bus.fault, e.flt);
      chk("retired", int'(bus.retired), int'(e.ret));
      if (e.dec >= 0) begin
        chk("isJal", bus.isJal, tbl[e.dec].jal);
        chk("isMvhi", bus.isMvhi, tbl[e.dec].mvhi);
        chk("useZeroExe", bus.useZeroExe, tbl[e.dec].zero);
        chk("useImmExe", bus.useImmExe, tbl[e.dec].imm);
        chk("isBranchOrCond", bus.isBranchOrCond, tbl[e.dec].brc);
        chk("opAlu", int'(bus.opAlu), int'(tbl[e.dec].alu));
        chk("opCond", int'(bus.opCond), int'(tbl[e.dec].op2));
        chk("wbSel", int'(bus.wbSel), int'(tbl[e.dec].wb));
      end
      if (e.pin) begin
        chk("pin_retired", int'(bus.retired), int'(e.pin_ret));
        chk("pin_model_retired", int'(e.ret), int'(e.pin_ret));
        chk("pin_fault", bus.fault, e.pin_flt);
      end
    end
  end

  // Record what this cycle must look like, then advance to just after the next edge.
  task automatic step(input bit ireq, input bit dreq, input bit wmem, input bit wreg,
                      input bit pcw, input bit immpc, input bit bsy, input int dec);
    exp_t e;
    e.ireq = ireq;  e.dreq = dreq;  e.wmem = wmem;  e.wreg = wreg;
    e.pcw = pcw;    e.immpc = immpc; e.bsy = bsy;   e.flt = m_fault;
    e.ret = m_retired[3:0];
    e.dec = dec;
    e.pin = p_en;   e.pin_ret = p_ret; e.pin_flt = p_flt;
    p_en = 1'b0;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic pin(input logic [3:0] r, input bit f);
    p_en = 1'b1;
    p_ret = r;
    p_flt = f;
  endtask

  task automatic idle(input bit l);
    bus.lock = l;
    step(0, 0, 0, 0, 0, 0, 0, -1);
  endtask

  // One instruction: (iw) unacked fetch cycles, decode, exec, optional mem with (dw) waits, wb.
  task automatic run_instr(input int k, input int iw, input int dw, input bit cond, input bit drop);
    bus.op1 = tbl[k].op1;
    bus.op2 = tbl[k].op2;
    bus.outCond = cond;
    for (int i = 0; i <= iw; i++) begin
      bus.imemAck = (i == iw);
      step(1, 0, 0, 0, 0, 0, 1, k);
    end
    bus.imemAck = 1'b0;
    step(0, 0, 0, 0, 0, 0, 1, k);
    step(0, 0, 0, 0, 0, 0, 1, k);
    if (tbl[k].mem != 0) begin
      for (int j = 0; j <= dw; j++) begin
        bus.dmemAck = (j == dw);
        if (drop && j == 0) bus.lock = 1'b0;
        step(0, 1, tbl[k].mem == 2, 0, 0, 0, 1, k);
      end
      bus.dmemAck = 1'b0;
    end
    step(0, 0, 0, tbl[k].regw, 1, tbl[k].br & cond, 1, k);
    m_retired++;
  endtask

  initial begin
    //             op1      op2      jal mvhi zero imm brc alu      wb    mem regw br
    tbl[I_ADD]  = '{4'b0000, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2'd0, 0, 1, 0};
    tbl[I_SW]   = '{4'b0101, 4'b0000, 0, 0, 0, 1, 0, 4'b0000, 2'd0, 2, 0, 0};
    tbl[I_BR]   = '{4'b0110, 4'b0100, 0, 0, 1, 0, 1, 4'b0110, 2'd0, 0, 0, 1};
    tbl[I_CMP]  = '{4'b0010, 4'b0001, 0, 0, 0, 0, 1, 4'b0110, 2'd0, 0, 1, 0};
    tbl[I_MVHI] = '{4'b1000, 4'b0011, 0, 1, 1, 1, 0, 4'b0011, 2'd0, 0, 1, 0};
    tbl[I_LW]   = '{4'b0001, 4'b0000, 0, 0, 0, 0, 0, 4'b0000, 2'd1, 1, 1, 0};
    tbl[I_JAL]  = '{4'b0011, 4'b0000, 1, 0, 0, 0, 0, 4'b0000, 2'd2, 0, 1, 0};

    resetN = 1'b0;
    bus.lock = 1'b0;
    bus.op1 = '0;
    bus.op2 = '0;
    bus.outCond = 1'b0;
    bus.imemAck = 1'b0;
    bus.dmemAck = 1'b0;
    @(posedge clk);
    #1;

    // Reset state.
    pin(4'd0, 1'b0);
    step(0, 0, 0, 0, 0, 0, 0, -1);
    resetN = 1'b1;
    idle(0);
    idle(0);
    idle(1);

    // ALU, store with 3 wait cycles, branch taken / not taken, compare, mvhi.
    run_instr(I_ADD, 0, 0, 0, 0);
    pin(4'd1, 1'b0);
    run_instr(I_SW, 0, 3, 0, 0);
    run_instr(I_BR, 0, 0, 1, 0);
    run_instr(I_BR, 1, 0, 0, 0);
    run_instr(I_CMP, 0, 0, 0, 0);
    run_instr(I_MVHI, 2, 0, 0, 0);

    // Load with lock dropped in MEM: completes, then parks in IDLE.
    run_instr(I_LW, 0, 1, 0, 1);
    idle(0);
    idle(0);
    idle(0);
    idle(1);

    // Acks arriving exactly at the timeout limit still win.
    run_instr(I_ADD, 4, 0, 0, 0);
    run_instr(I_LW, 0, 4, 0, 0);

    // 16 JALs: retire count wraps 15 -> 0 (9 retired before this loop).
    for (int i = 0; i < 16; i++) begin
      if (i == 7) pin(4'd0, 1'b0);
      run_instr(I_JAL, i % 2, 0, 0, 0);
    end
    pin(4'd9, 1'b0);

    // Reset in the middle of a fetch handshake.
    bus.op1 = tbl[I_ADD].op1;
    bus.op2 = tbl[I_ADD].op2;
    bus.imemAck = 1'b0;
    step(1, 0, 0, 0, 0, 0, 1, I_ADD);
    resetN = 1'b0;
    step(1, 0, 0, 0, 0, 0, 1, I_ADD);
    m_retired = 0;
    resetN = 1'b1;
    pin(4'd0, 1'b0);
    idle(0);

    // Fetch never acked: limit of 4 exceeded -> HALT with sticky fault until reset.
    idle(1);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0, 0, 0, 1, I_ADD);
    m_fault = 1'b1;
    pin(4'd0, 1'b1);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 0, 0, -1);
    resetN = 1'b0;
    step(0, 0, 0, 0, 0, 0, 0, -1);
    m_fault = 1'b0;
    resetN = 1'b1;
    bus.lock = 1'b0;
    pin(4'd0, 1'b0);
    idle(0);

    @(negedge clk);
    #1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
